// File: rtl/hwmem_arbiter_pkg.sv
// Shared types for the two-core memory arbiter: data width, request record,
// round-robin pointer encoding and the 2-way pick function.
package hwmem_arbiter_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned NUM_REQ_CFG = 2;
  localparam int unsigned ADDR_W_MAX  = 32;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_MAX-1:0] addr;
    logic [XLEN/8-1:0]     be;
    logic [XLEN-1:0]       wdata;
  } hwmem_req_t;

  // Which requester received the most recent grant on a channel
  typedef enum logic {
    LAST_0 = 1'b0,
    LAST_1 = 1'b1
  } rr_last_e;

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input rr_last_e last);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == LAST_0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/hwmem_arbiter_if.sv
// Requester and memory-port bundle for hwmem_arbiter; slave = arbiter side,
// master = cores plus memory model side.
interface hwmem_arbiter_if #(
  parameter int unsigned LINES   = 4096,
  parameter int unsigned NUM_REQ = 2
);
  import hwmem_arbiter_pkg::*;

  localparam int unsigned AW = $clog2(LINES);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][AW-1:0]     req_addr;
  logic [NUM_REQ-1:0][XLEN/8-1:0] req_be;
  logic [NUM_REQ-1:0][XLEN-1:0]   req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [XLEN-1:0]                rsp_rdata;

  logic                           mem_en_a;
  logic [AW-1:0]                  mem_addr_a;
  logic [XLEN-1:0]                mem_data_out_a;
  logic [AW-1:0]                  mem_addr_b;
  logic [XLEN/8-1:0]              mem_be_b;
  logic [XLEN-1:0]                mem_data_in_b;

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, mem_data_out_a,
    output req_ready, rsp_valid, rsp_rdata,
           mem_en_a, mem_addr_a, mem_addr_b, mem_be_b, mem_data_in_b
  );

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, mem_data_out_a,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_en_a, mem_addr_a, mem_addr_b, mem_be_b, mem_data_in_b
  );

endinterface

// File: rtl/hwmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// moves only on cycles that grant.
module rr_arb2
  import hwmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  rr_last_e last_q, last_d;

  // Reset to "core 1 won last" so core 0 takes the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = LAST_0;
    end else if (gnt_o[1]) begin
      last_d = LAST_1;
    end
  end

  always_comb begin
    gnt_o = rr_pick(req_i, last_q);
  end

endmodule

// File: rtl/hwmem_arbiter.sv
// Two-core shared-memory arbiter: independent read (port A) and write
// (port B) channels, each round-robin, write-first on address hazards.
module hwmem_arbiter
  import hwmem_arbiter_pkg::*;
#(
  parameter int unsigned LINES   = 4096,
  parameter int unsigned NUM_REQ = NUM_REQ_CFG
) (
  input logic            clk,
  input logic            rst_n,
  hwmem_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(LINES);

  hwmem_req_t         req_s [NUM_REQ];
  logic [NUM_REQ-1:0] wr_req, rd_raw, rd_hz, rd_req;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic               wr_any, rd_any;
  logic               wr_idx, rd_idx;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic [AW-1:0]      addr_a_q, addr_a_d;
  logic [AW-1:0]      addr_b_q, addr_b_d;
  logic [XLEN-1:0]    wdata_b_q, wdata_b_d;

  // Requests are masked by rst_n so nothing is granted while in reset
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_s[i].we    = bus.req_we[i];
      req_s[i].addr  = ADDR_W_MAX'(bus.req_addr[i]);
      req_s[i].be    = bus.req_be[i];
      req_s[i].wdata = bus.req_wdata[i];
      wr_req[i]      = rst_n & bus.req_valid[i] & req_s[i].we;
      rd_raw[i]      = rst_n & bus.req_valid[i] & ~req_s[i].we;
    end
  end

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (wr_req),
    .gnt_o (wr_gnt)
  );

  // A read to the address being written this cycle waits one cycle, so it
  // observes the new data instead of the pre-write contents
  always_comb begin
    wr_any = |wr_gnt;
    wr_idx = wr_gnt[1];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rd_hz[i] = wr_any && (req_s[i].addr == req_s[wr_idx].addr);
    end
    rd_req = rd_raw & ~rd_hz;
  end

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (rd_req),
    .gnt_o (rd_gnt)
  );

  always_comb begin
    rd_any         = |rd_gnt;
    rd_idx         = rd_gnt[1];

    addr_a_d       = rd_any ? req_s[rd_idx].addr[AW-1:0] : addr_a_q;
    addr_b_d       = wr_any ? req_s[wr_idx].addr[AW-1:0] : addr_b_q;
    wdata_b_d      = wr_any ? req_s[wr_idx].wdata : wdata_b_q;
    rdata_d        = (|rsp_valid_q) ? bus.mem_data_out_a : rdata_q;

    bus.req_ready  = rd_gnt | wr_gnt;
    bus.mem_en_a   = rd_any;
    bus.mem_addr_a = addr_a_d;
    bus.mem_be_b   = wr_any ? req_s[wr_idx].be : '0;
    bus.mem_addr_b = addr_b_d;
    bus.mem_data_in_b = wdata_b_d;
    bus.rsp_valid  = rsp_valid_q;
    bus.rsp_rdata  = rdata_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      wdata_b_q   <= '0;
    end else begin
      rsp_valid_q <= rd_gnt;
      rdata_q     <= rdata_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      wdata_b_q   <= wdata_b_d;
    end
  end

endmodule
